// File: rtl/sgmii_tx_sched_pkg.sv
// Shared types and constants for the SGMII transmit frame scheduler.
package sgmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_PAD   = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } sched_state_e;

  localparam logic [7:0] C_PAD_BYTE     = 8'h00;
  localparam int         C_IFG_BYTES    = 12;
  localparam int         C_PREAMBLE_LEN = 8;

  // One registered beat towards sgmii_tx.
  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } tx_beat_t;

  // Per-frame completion pulses, registered alongside the closing beat.
  typedef struct packed {
    logic done;
    logic underrun;
    logic truncated;
  } frame_status_t;

endpackage

// File: rtl/sgmii_tx_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // Walk offsets from farthest to nearest so the closest hit to ptr wins.
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = PW'(k);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgmii_tx_sched.sv
// Frame scheduler in front of sgmii_tx: round-robin grant among byte-stream
// requesters, contiguous sof/data/eof burst, runt padding, MAX_LEN cut and
// inter-frame gap. Sole driver of the sgmii_tx beat interface.
module sgmii_tx_sched
  import sgmii_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MIN_LEN    = 60,
  parameter int GAP_CYCLES = C_IFG_BYTES + C_PREAMBLE_LEN,
  parameter int MAX_LEN    = 1514
) (
  input  logic               clk_125M,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_eof,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               frame_done,
  output logic               underrun,
  output logic               truncated
);

  localparam int PW = $clog2(N_REQ);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  sched_state_e                state, state_nxt;
  logic [LW-1:0]               len_cnt, len_nxt, len_inc;
  logic [GW-1:0]               gap_cnt, gap_nxt;
  logic [PW-1:0]               rr_ptr, rr_nxt, gidx, gidx_nxt;
  logic [N_REQ-1:0]            grant_nxt;
  tx_beat_t                    beat, beat_nxt;
  frame_status_t               stat, stat_nxt;
  logic                        to_gap;

  logic [N_REQ-1:0][7:0]       lane_data;
  logic [7:0]                  sel_data;
  logic                        sel_valid, sel_eof;

  logic [N_REQ-1:0]            arb_grant;
  logic [PW-1:0]               arb_idx;
  logic                        arb_valid;

  // Unpack the flat byte bus into per-lane bytes.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[8*i +: 8];
  end

  assign sel_data  = lane_data[gidx];
  assign sel_valid = req_valid[gidx];
  assign sel_eof   = req_eof[gidx];
  assign len_inc   = len_cnt + LW'(1);

  assign tx_sof     = beat.sof;
  assign tx_eof     = beat.eof;
  assign tx_data    = beat.data;
  assign frame_done = stat.done;
  assign underrun   = stat.underrun;
  assign truncated  = stat.truncated;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next-state, next-beat and combinational req_ready.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    gap_nxt   = gap_cnt;
    rr_nxt    = rr_ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant;
    beat_nxt  = '0;
    stat_nxt  = '0;
    req_ready = '0;
    to_gap    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          grant_nxt = arb_grant;
          gidx_nxt  = arb_idx;
          len_nxt   = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (sel_valid) begin
          req_ready     = grant;
          beat_nxt.data = sel_data;
          beat_nxt.sof  = (len_cnt == '0);
          len_nxt       = len_inc;
          if (sel_eof) begin
            if (len_inc >= LW'(MIN_LEN)) begin
              beat_nxt.eof  = 1'b1;
              stat_nxt.done = 1'b1;
              to_gap        = 1'b1;
            end else begin
              state_nxt = S_PAD;
            end
          end else if (len_inc == LW'(MAX_LEN)) begin
            beat_nxt.eof       = 1'b1;
            stat_nxt.truncated = 1'b1;
            state_nxt          = S_DRAIN;
          end
        end else begin
          // Requester starved the frame: close it with a zero byte. If
          // nothing was sent yet there is no open frame to close.
          beat_nxt.data     = C_PAD_BYTE;
          beat_nxt.eof      = (len_cnt != '0);
          stat_nxt.underrun = 1'b1;
          to_gap            = 1'b1;
        end
      end
      S_PAD: begin
        beat_nxt.data = C_PAD_BYTE;
        len_nxt       = len_inc;
        if (len_inc == LW'(MIN_LEN)) begin
          beat_nxt.eof  = 1'b1;
          stat_nxt.done = 1'b1;
          to_gap        = 1'b1;
        end
      end
      S_DRAIN: begin
        req_ready = grant;
        if (!sel_valid || sel_eof) to_gap = 1'b1;
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          rr_nxt    = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (to_gap) begin
      grant_nxt = '0;
      gap_nxt   = '0;
      len_nxt   = '0;
      state_nxt = S_GAP;
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk_125M or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      len_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      gidx    <= '0;
      grant   <= '0;
      beat    <= '0;
      stat    <= '0;
    end else begin
      state   <= state_nxt;
      len_cnt <= len_nxt;
      gap_cnt <= gap_nxt;
      rr_ptr  <= rr_nxt;
      gidx    <= gidx_nxt;
      grant   <= grant_nxt;
      beat    <= beat_nxt;
      stat    <= stat_nxt;
    end
  end

endmodule
